// File: rtl/raster_pkg.sv
// Shared types and width helpers for the triangle rasterizer.
package raster_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, SCAN, DONE} state_t;

    function automatic int det_width(input int cw);
        return 2 * cw + 3;
    endfunction

    function automatic int count_width(input int cols, input int rows);
        return $clog2((cols + 1) * (rows + 1) + 1);
    endfunction

endpackage

// File: rtl/tri_abs_det.sv
// Combinational |det(U,V,W)|, i.e. twice the unsigned area of triangle UVW.
module tri_abs_det
    import raster_pkg::*;
#(
    parameter int CW = 10
) (
    input  logic [CW-1:0]            ux,
    input  logic [CW-1:0]            uy,
    input  logic [CW-1:0]            vx,
    input  logic [CW-1:0]            vy,
    input  logic [CW-1:0]            wx,
    input  logic [CW-1:0]            wy,
    output logic [det_width(CW)-1:0] det_abs
);
    localparam int DW = det_width(CW);

    logic signed [DW-1:0] sux, suy, svx, svy, swx, swy, det;

    // DW bits hold the full signed result, so truncating the products is exact.
    always_comb begin
        sux     = $signed({{(DW-CW){1'b0}}, ux});
        suy     = $signed({{(DW-CW){1'b0}}, uy});
        svx     = $signed({{(DW-CW){1'b0}}, vx});
        svy     = $signed({{(DW-CW){1'b0}}, vy});
        swx     = $signed({{(DW-CW){1'b0}}, wx});
        swy     = $signed({{(DW-CW){1'b0}}, wy});
        det     = sux * (svy - swy) + svx * (swy - suy) + swx * (suy - svy);
        det_abs = det[DW-1] ? $unsigned(-det) : $unsigned(det);
    end

endmodule

// File: rtl/triangle_raster_scan.sv
// Triangle rasterizer: scans the grid top row first and streams one inside flag per pixel.
//  state | meaning
//  IDLE  | waiting for start, vertices captured on start
//  SETUP | |ABC| and degenerate resolved, first pixel record loaded
//  SCAN  | streaming records, advance on valid&ready
//  DONE  | one-cycle done pulse
module triangle_raster_scan
    import raster_pkg::*;
#(
    parameter int CW       = 10,
    parameter int MAX_COLS = 75,
    parameter int MAX_ROWS = 50
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start,
    input  logic [CW-1:0]                            ax,
    input  logic [CW-1:0]                            ay,
    input  logic [CW-1:0]                            bx,
    input  logic [CW-1:0]                            by,
    input  logic [CW-1:0]                            cx,
    input  logic [CW-1:0]                            cy,
    output logic                                     busy,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [CW-1:0]                            out_px,
    output logic [CW-1:0]                            out_py,
    output logic                                     out_inside,
    output logic                                     out_eol,
    output logic                                     out_last,
    output logic                                     degenerate,
    output logic [count_width(MAX_COLS, MAX_ROWS)-1:0] inside_count,
    output logic                                     done
);
    localparam int DW = det_width(CW);
    localparam int NW = count_width(MAX_COLS, MAX_ROWS);
    localparam logic [CW-1:0] LAST_COL = CW'(MAX_COLS);
    localparam logic [CW-1:0] LAST_ROW = CW'(MAX_ROWS);

    state_t          state_q, state_d;
    logic [CW-1:0]   ax_q, ay_q, bx_q, by_q, cx_q, cy_q;
    logic [CW-1:0]   ax_d, ay_d, bx_d, by_d, cx_d, cy_d;
    logic [CW-1:0]   px_q, py_q, px_d, py_d;
    logic            valid_q, valid_d, inside_q, inside_d, eol_q, eol_d, last_q, last_d;
    logic            busy_q, busy_d, degen_q, degen_d, done_q, done_d;
    logic [NW-1:0]   count_q, count_d;

    logic [CW-1:0]   nxt_px, nxt_py;
    logic [DW-1:0]   abc_abs, abp_abs, apc_abs, pbc_abs;
    logic [DW+1:0]   edge_sum;
    logic            accept, deg_now, inside_now;

    assign accept = (state_q == SCAN) && valid_q && out_ready;

    // Coordinates of the record that will be registered at the next edge.
    always_comb begin
        nxt_px = px_q;
        nxt_py = py_q;
        if (state_q == SETUP) begin
            nxt_px = '0;
            nxt_py = LAST_ROW;
        end else if (accept && !last_q) begin
            if (px_q == LAST_COL) begin
                nxt_px = '0;
                nxt_py = py_q - CW'(1);
            end else begin
                nxt_px = px_q + CW'(1);
            end
        end
    end

    tri_abs_det #(.CW(CW)) u_abc (.ux(ax_q), .uy(ay_q), .vx(bx_q), .vy(by_q),
                                  .wx(cx_q), .wy(cy_q), .det_abs(abc_abs));
    tri_abs_det #(.CW(CW)) u_abp (.ux(ax_q), .uy(ay_q), .vx(bx_q), .vy(by_q),
                                  .wx(nxt_px), .wy(nxt_py), .det_abs(abp_abs));
    tri_abs_det #(.CW(CW)) u_apc (.ux(ax_q), .uy(ay_q), .vx(nxt_px), .vy(nxt_py),
                                  .wx(cx_q), .wy(cy_q), .det_abs(apc_abs));
    tri_abs_det #(.CW(CW)) u_pbc (.ux(nxt_px), .uy(nxt_py), .vx(bx_q), .vy(by_q),
                                  .wx(cx_q), .wy(cy_q), .det_abs(pbc_abs));

    assign deg_now    = (abc_abs == '0);
    assign edge_sum   = {2'b00, abp_abs} + {2'b00, apc_abs} + {2'b00, pbc_abs};
    assign inside_now = (edge_sum == {2'b00, abc_abs}) && !deg_now;

    always_comb begin
        state_d  = state_q;
        ax_d = ax_q; ay_d = ay_q; bx_d = bx_q; by_d = by_q; cx_d = cx_q; cy_d = cy_q;
        px_d     = px_q;
        py_d     = py_q;
        valid_d  = valid_q;
        inside_d = inside_q;
        eol_d    = eol_q;
        last_d   = last_q;
        busy_d   = busy_q;
        degen_d  = degen_q;
        count_d  = count_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    ax_d = ax; ay_d = ay; bx_d = bx; by_d = by; cx_d = cx; cy_d = cy;
                    busy_d  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                degen_d  = deg_now;
                count_d  = '0;
                px_d     = nxt_px;
                py_d     = nxt_py;
                valid_d  = 1'b1;
                inside_d = inside_now;
                eol_d    = (nxt_px == LAST_COL);
                last_d   = (nxt_px == LAST_COL) && (nxt_py == '0);
                state_d  = SCAN;
            end
            SCAN: begin
                if (accept) begin
                    count_d = count_q + NW'(inside_q);
                    if (last_q) begin
                        valid_d  = 1'b0;
                        inside_d = 1'b0;
                        eol_d    = 1'b0;
                        last_d   = 1'b0;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        state_d  = DONE;
                    end else begin
                        px_d     = nxt_px;
                        py_d     = nxt_py;
                        inside_d = inside_now;
                        eol_d    = (nxt_px == LAST_COL);
                        last_d   = (nxt_px == LAST_COL) && (nxt_py == '0);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ax_q <= '0; ay_q <= '0; bx_q <= '0; by_q <= '0; cx_q <= '0; cy_q <= '0;
            px_q     <= '0;
            py_q     <= '0;
            valid_q  <= 1'b0;
            inside_q <= 1'b0;
            eol_q    <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            degen_q  <= 1'b0;
            count_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ax_q <= ax_d; ay_q <= ay_d; bx_q <= bx_d; by_q <= by_d; cx_q <= cx_d; cy_q <= cy_d;
            px_q     <= px_d;
            py_q     <= py_d;
            valid_q  <= valid_d;
            inside_q <= inside_d;
            eol_q    <= eol_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            degen_q  <= degen_d;
            count_q  <= count_d;
            done_q   <= done_d;
        end
    end

    assign busy         = busy_q;
    assign out_valid    = valid_q;
    assign out_px       = px_q;
    assign out_py       = py_q;
    assign out_inside   = inside_q;
    assign out_eol      = eol_q;
    assign out_last     = last_q;
    assign degenerate   = degen_q;
    assign inside_count = count_q;
    assign done         = done_q;

endmodule

// File: tb/tb_triangle_raster_scan.sv
// Directed bench for triangle_raster_scan with hand-computed pixel counts and probes.
module tb_triangle_raster_scan;
    localparam int CW   = 10;
    localparam int MC   = 75;
    localparam int MR   = 50;
    localparam int NREC = (MC + 1) * (MR + 1);

    logic          clk = 1'b0;
    logic          rst, start, out_ready;
    logic [CW-1:0] ax, ay, bx, by, cx, cy;
    logic          busy, out_valid, out_inside, out_eol, out_last, degenerate, done;
    logic [CW-1:0] out_px, out_py;
    logic [11:0]   inside_count;

    int n_checks = 0;
    int n_pass   = 0;
    int n_rec, n_ins, n_eol, n_done, ord_err;
    bit ins_map [0:MC][0:MR];

    always #5 clk = ~clk;

    triangle_raster_scan #(.CW(CW), .MAX_COLS(MC), .MAX_ROWS(MR)) dut (
        .clk(clk), .rst(rst), .start(start),
        .ax(ax), .ay(ay), .bx(bx), .by(by), .cx(cx), .cy(cy),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_px(out_px), .out_py(out_py), .out_inside(out_inside),
        .out_eol(out_eol), .out_last(out_last), .degenerate(degenerate),
        .inside_count(inside_count), .done(done)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_verts(input int a_x, input int a_y, input int b_x, input int b_y,
                             input int c_x, input int c_y);
        ax = CW'(a_x); ay = CW'(a_y);
        bx = CW'(b_x); by = CW'(b_y);
        cx = CW'(c_x); cy = CW'(c_y);
    endtask

    task automatic start_job(input string tag, input int a_x, input int a_y, input int b_x,
                             input int b_y, input int c_x, input int c_y);
        set_verts(a_x, a_y, b_x, b_y, c_x, c_y);
        start = 1'b1;
        step();
        start = 1'b0;
        check_val({tag, "_setup_valid"}, int'(out_valid), 0);
        check_val({tag, "_setup_busy"}, int'(busy), 1);
        step();
        check_val({tag, "_first_valid"}, int'(out_valid), 1);
        check_val({tag, "_first_pos"}, int'(out_px) * 100 + int'(out_py), 50);
    endtask

    task automatic run_scan(input string tag, input int stall_at, input int poke_at);
        int exp_px = 0;
        int exp_py = MR;
        int post   = 0;
        int cap_px, cap_py, cap_in;
        bit fin = 1'b0;
        bit stalled = 1'b0;
        n_rec = 0; n_ins = 0; n_eol = 0; n_done = 0; ord_err = 0;
        for (int cyc = 0; cyc < 8000 && !fin; cyc++) begin
            if (out_valid && n_rec == stall_at && !stalled) begin
                stalled = 1'b1;
                out_ready = 1'b0;
                cap_px = int'(out_px);
                cap_py = int'(out_py);
                cap_in = int'(out_inside);
                check_val({tag, "_stall_pos"}, cap_px * 100 + cap_py, exp_px * 100 + exp_py);
                for (int s = 0; s < 3; s++) begin
                    step();
                    check_val({tag, "_stall_px"}, int'(out_px), cap_px);
                    check_val({tag, "_stall_py"}, int'(out_py), cap_py);
                    check_val({tag, "_stall_in"}, int'(out_inside), cap_in);
                    check_val({tag, "_stall_valid"}, int'(out_valid), 1);
                end
                out_ready = 1'b1;
            end
            start = 1'b0;
            if (out_valid && n_rec == poke_at) begin
                set_verts(5, 5, 6, 40, 70, 2);
                start = 1'b1;
            end
            if (done) n_done++;
            if (out_valid && out_ready) begin
                if (int'(out_px) != exp_px || int'(out_py) != exp_py) ord_err++;
                if (out_eol !== (exp_px == MC)) ord_err++;
                if (out_last !== (exp_px == MC && exp_py == 0)) ord_err++;
                if (exp_py >= 0) ins_map[exp_px][exp_py] = out_inside;
                n_rec++;
                n_ins += int'(out_inside);
                n_eol += int'(out_eol);
                if (exp_px == MC) begin
                    exp_px = 0;
                    exp_py--;
                end else begin
                    exp_px++;
                end
            end
            if (n_done > 0) post++;
            fin = (post >= 3);
            step();
        end
        start = 1'b0;
        check_val({tag, "_finished"}, int'(fin), 1);
    endtask

    initial begin
        int acc;
        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b1;
        set_verts(0, 0, 0, 0, 0, 0);
        repeat (3) step();
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_valid", int'(out_valid), 0);
        check_val("rst_done", int'(done), 0);
        check_val("rst_degen", int'(degenerate), 0);
        check_val("rst_count", int'(inside_count), 0);
        check_val("rst_pos", int'(out_px) + int'(out_py), 0);
        check_val("rst_flags", int'(out_inside) + int'(out_eol) + int'(out_last), 0);
        rst = 1'b0;
        step();

        // Right triangle with legs 10 and 30: 176 lattice points
        start_job("t1", 0, 0, 10, 0, 0, 30);
        run_scan("t1", -1, -1);
        check_val("t1_records", n_rec, NREC);
        check_val("t1_inside", n_ins, 176);
        check_val("t1_count", int'(inside_count), 176);
        check_val("t1_degen", int'(degenerate), 0);
        check_val("t1_done", n_done, 1);
        check_val("t1_order", ord_err, 0);
        check_val("t1_eols", n_eol, MR + 1);
        check_val("t1_busy_after", int'(busy), 0);
        check_val("t2_0_0", int'(ins_map[0][0]), 1);
        check_val("t2_10_0", int'(ins_map[10][0]), 1);
        check_val("t2_5_15", int'(ins_map[5][15]), 1);
        check_val("t2_0_30", int'(ins_map[0][30]), 1);
        check_val("t2_11_0", int'(ins_map[11][0]), 0);
        check_val("t2_6_15", int'(ins_map[6][15]), 0);
        check_val("t2_0_31", int'(ins_map[0][31]), 0);
        check_val("t2_75_50", int'(ins_map[75][50]), 0);

        start_job("t3", 0, 0, 5, 5, 10, 10);
        run_scan("t3", -1, -1);
        check_val("t3_degen", int'(degenerate), 1);
        check_val("t3_inside", n_ins, 0);
        check_val("t3_count", int'(inside_count), 0);
        check_val("t3_records", n_rec, NREC);
        check_val("t3_done", n_done, 1);

        start_job("t4", 0, 0, 10, 0, 0, 30);
        run_scan("t4", 100, -1);
        check_val("t4_records", n_rec, NREC);
        check_val("t4_inside", n_ins, 176);
        check_val("t4_count", int'(inside_count), 176);
        check_val("t4_order", ord_err, 0);

        start_job("t5", 0, 0, 10, 0, 0, 30);
        acc = 0;
        for (int c = 0; c < 2000 && acc < 500; c++) begin
            if (out_valid && out_ready) acc++;
            step();
        end
        check_val("t5_reached", acc, 500);
        rst = 1'b1;
        step();
        check_val("t5_valid", int'(out_valid), 0);
        check_val("t5_busy", int'(busy), 0);
        check_val("t5_count", int'(inside_count), 0);
        rst = 1'b0;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            if (done || out_valid) acc++;
            step();
        end
        check_val("t5_quiet", acc, 0);
        start_job("t5r", 0, 0, 10, 0, 0, 30);
        run_scan("t5r", -1, -1);
        check_val("t5r_records", n_rec, NREC);
        check_val("t5r_count", int'(inside_count), 176);

        start_job("t6", 0, 0, 10, 0, 0, 30);
        run_scan("t6", -1, 300);
        check_val("t6_records", n_rec, NREC);
        check_val("t6_inside", n_ins, 176);
        check_val("t6_count", int'(inside_count), 176);
        check_val("t6_done", n_done, 1);

        // Legs of 4 from (2,2): 5+4+3+2+1 points
        start_job("t7", 2, 2, 2, 6, 6, 2);
        run_scan("t7", -1, -1);
        check_val("t7_count", int'(inside_count), 15);
        check_val("t7_2_6", int'(ins_map[2][6]), 1);
        check_val("t7_4_5", int'(ins_map[4][5]), 0);

        // Mostly off-grid: only cols 70..75 of rows 48..50 are visible
        start_job("t8", 70, 48, 80, 48, 70, 58);
        run_scan("t8", -1, -1);
        check_val("t8_count", int'(inside_count), 18);
        check_val("t8_75_50", int'(ins_map[75][50]), 1);
        check_val("t8_69_48", int'(ins_map[69][48]), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
